// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage ALU/MDU: op codes, result classes, common constants.
// No logic; constants and the divider state type only.
// Imported by ex_mdu and div_unit.
package ex_mdu_pkg;

    // Reset is asserted low; write enable is asserted high.
    localparam logic        RstEnable   = 1'b0;
    localparam logic        WriteEnable = 1'b1;
    // Wide enough for the largest legal datapath; users slice to WIDTH.
    localparam logic [63:0] ZeroWord    = 64'h0;

    // Operation codes (aluOp_i).
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_MUL   = 8'b1010_1001;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    // Result classes (aluSel_i).
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_MUL   = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned.
// Latency: WIDTH+2 cycles from start to result write (2 for divide-by-zero).
// stall_o held from the start cycle through BUSY; annul_i aborts to IDLE.
module div_unit
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   quo_q;     // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_quo_q, neg_rem_q;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mag1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Partial remainder is always below the divisor, so the trial fits in
    // WIDTH+1 bits and its MSB is the borrow.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    assign quo_fix  = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;
    assign result_o = {rem_fix, quo_fix};

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) state_q <= IDLE;
        else                  state_q <= state_d;
    end

    // Next state, stall and ready.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    stall_o = 1'b1;
                    state_d = (opdata2_i == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_o = !annul_i;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and one restoring step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q     <= '0;
            quo_q     <= ZeroWord[WIDTH-1:0];
            rem_q     <= ZeroWord[WIDTH-1:0];
            dvs_q     <= ZeroWord[WIDTH-1:0];
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        cnt_q <= '0;
                        if (opdata2_i == '0) begin
                            quo_q     <= '1;
                            rem_q     <= opdata1_i;
                            dvs_q     <= ZeroWord[WIDTH-1:0];
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else begin
                            quo_q     <= mag1;
                            rem_q     <= ZeroWord[WIDTH-1:0];
                            dvs_q     <= mag2;
                            neg_quo_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem_q <= signed_i && opdata1_i[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    if (!annul_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!trial[WIDTH]) begin
                            rem_q <= trial[WIDTH-1:0];
                            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q <= shifted[WIDTH-1:0];
                            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: logic/shift/arith/move/multiply results plus HI/LO and iterative divide.
// Latency: combinational writeback; MULT/MTHI/MTLO at next edge; divide WIDTH+2 cycles.
// stallreq_o asserted from divide acceptance through BUSY; flush_i aborts the divide.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluOp_i,
    input  logic [2:0]        aluSel_i,
    input  logic [WIDTH-1:0]  reg1_i,
    input  logic [WIDTH-1:0]  reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [WIDTH-1:0]  wdata_o,
    output logic [WIDTH-1:0]  hi_o,
    output logic [WIDTH-1:0]  lo_o,
    output logic              stallreq_o
);

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum, diff;
    logic               ov_add, ov_sub;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   logic_res, shift_res, arith_res, move_res;
    logic               div_op, div_stall, div_ready;
    logic [2*WIDTH-1:0] div_result;

    assign shamt  = reg1_i[SHAMT_W-1:0];
    assign sum    = reg1_i + reg2_i;
    assign diff   = reg1_i - reg2_i;
    assign ov_add = (reg1_i[WIDTH-1] == reg2_i[WIDTH-1]) && (sum[WIDTH-1]  != reg1_i[WIDTH-1]);
    assign ov_sub = (reg1_i[WIDTH-1] != reg2_i[WIDTH-1]) && (diff[WIDTH-1] != reg1_i[WIDTH-1]);

    // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{WIDTH{reg1_i[WIDTH-1]}}, reg1_i} * {{WIDTH{reg2_i[WIDTH-1]}}, reg2_i};
    assign prod_u = {{WIDTH{1'b0}}, reg1_i} * {{WIDTH{1'b0}}, reg2_i};

    assign div_op = is_div_op(aluOp_i);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    div_unit #(.WIDTH(WIDTH)) u_div_unit (
        .clk       (clk),
        .rst       (rst),
        .start_i   (div_op),
        .signed_i  (aluOp_i == OP_DIV),
        .annul_i   (flush_i),
        .opdata1_i (reg1_i),
        .opdata2_i (reg2_i),
        .stall_o   (div_stall),
        .ready_o   (div_ready),
        .result_o  (div_result)
    );

    // Per-class result candidates.
    always_comb begin
        logic_res = ZeroWord[WIDTH-1:0];
        shift_res = ZeroWord[WIDTH-1:0];
        arith_res = ZeroWord[WIDTH-1:0];
        move_res  = ZeroWord[WIDTH-1:0];
        case (aluOp_i)
            OP_OR:  logic_res = reg1_i | reg2_i;
            OP_AND: logic_res = reg1_i & reg2_i;
            OP_NOR: logic_res = ~(reg1_i | reg2_i);
            OP_XOR: logic_res = reg1_i ^ reg2_i;
            default: ;
        endcase
        case (aluOp_i)
            OP_SLL: shift_res = reg2_i << shamt;
            OP_SRL: shift_res = reg2_i >> shamt;
            OP_SRA: shift_res = $unsigned($signed(reg2_i) >>> shamt);
            default: ;
        endcase
        case (aluOp_i)
            OP_ADD, OP_ADDI, OP_ADDU: arith_res = sum;
            OP_SUB, OP_SUBU:          arith_res = diff;
            OP_SLT:  arith_res = {{(WIDTH-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLTU: arith_res = {{(WIDTH-1){1'b0}}, (reg1_i < reg2_i)};
            default: ;
        endcase
        case (aluOp_i)
            OP_MFHI: move_res = hi_q;
            OP_MFLO: move_res = lo_q;
            default: ;
        endcase
    end

    // Writeback selection, overflow suppression and stall; all zero in reset.
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = ZeroWord[WIDTH-1:0];
        stallreq_o = div_stall;
        case (aluSel_i)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            SEL_ARITH: wdata_o = arith_res;
            SEL_MOVE:  wdata_o = move_res;
            SEL_MUL:   wdata_o = prod_s[WIDTH-1:0];
            SEL_NOP:   wdata_o = ZeroWord[WIDTH-1:0];
            default:   wdata_o = ZeroWord[WIDTH-1:0];
        endcase
        if ((((aluOp_i == OP_ADD) || (aluOp_i == OP_ADDI)) && ov_add) ||
            ((aluOp_i == OP_SUB) && ov_sub) || div_op) begin
            wreg_o = ~WriteEnable;
        end
        if (rst == RstEnable) begin
            wd_o       = '0;
            wreg_o     = ~WriteEnable;
            wdata_o    = ZeroWord[WIDTH-1:0];
            stallreq_o = 1'b0;
        end
    end

    // HI/LO update; a completing divide beats any same-cycle MULT/MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q <= ZeroWord[WIDTH-1:0];
            lo_q <= ZeroWord[WIDTH-1:0];
        end else if (div_ready) begin
            hi_q <= div_result[2*WIDTH-1:WIDTH];
            lo_q <= div_result[WIDTH-1:0];
        end else if (!flush_i) begin
            case (aluOp_i)
                OP_MULT:  {hi_q, lo_q} <= prod_s;
                OP_MULTU: {hi_q, lo_q} <= prod_u;
                OP_MTHI:  hi_q <= reg1_i;
                OP_MTLO:  lo_q <= reg1_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu at WIDTH=32 with hand-computed expected values.
// Inputs change #1 after a rising edge; outputs are sampled a further #1 later.
// Every comparison goes through chk; one summary line at the end.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluOp_i;
    logic [2:0]  aluSel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_mdu dut (
        .clk        (clk),
        .rst        (rst),
        .aluOp_i    (aluOp_i),
        .aluSel_i   (aluSel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .flush_i    (flush_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        aluOp_i  = op;
        aluSel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        #1;
    endtask

    // Present a divide, count stall cycles, put an MTHI on the DONE cycle
    // (which must lose to the divide), then check HI/LO after that edge.
    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = 0;
        wreg_i = 1'b1;
        drive(op, SEL_NOP, a, b);
        chk({tag, "_wreg"}, 32'(wreg_o), 32'd0);
        for (int i = 0; i < 60; i++) begin
            if (!stallreq_o) break;
            n++;
            tick();
        end
        chk({tag, "_stall_cycles"}, n, exp_stall);
        drive(OP_MTHI, SEL_NOP, 32'hDEADBEEF, 32'h0);
        tick();
        chk({tag, "_hi"}, hi_o, exp_hi);
        chk({tag, "_lo"}, lo_o, exp_lo);
        drive(OP_OR, SEL_LOGIC, 32'h0, 32'h0);
    endtask

    initial begin
        rst     = 1'b0;
        wd_i    = 5'd7;
        wreg_i  = 1'b1;
        flush_i = 1'b0;
        drive(OP_ADD, SEL_ARITH, 32'h7FFFFFFF, 32'h1);
        tick();
        tick();
        chk("rst_hi",    hi_o, 32'h0);
        chk("rst_lo",    lo_o, 32'h0);
        chk("rst_wd",    32'(wd_o), 32'h0);
        chk("rst_wreg",  32'(wreg_o), 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_stall", 32'(stallreq_o), 32'h0);

        rst  = 1'b1;
        wd_i = 5'd5;
        drive(OP_ADD, SEL_ARITH, 32'h7FFFFFFF, 32'h1);
        chk("add_ov_dat",  wdata_o, 32'h80000000);
        chk("add_ov_wreg", 32'(wreg_o), 32'h0);
        chk("add_wd",      32'(wd_o), 32'd5);
        drive(OP_ADDU, SEL_ARITH, 32'h7FFFFFFF, 32'h1);
        chk("addu_dat",  wdata_o, 32'h80000000);
        chk("addu_wreg", 32'(wreg_o), 32'h1);
        drive(OP_ADDI, SEL_ARITH, 32'h80000000, 32'hFFFFFFFF);
        chk("addi_ov_dat",  wdata_o, 32'h7FFFFFFF);
        chk("addi_ov_wreg", 32'(wreg_o), 32'h0);
        drive(OP_SUB, SEL_ARITH, 32'h80000000, 32'h1);
        chk("sub_ov_dat",  wdata_o, 32'h7FFFFFFF);
        chk("sub_ov_wreg", 32'(wreg_o), 32'h0);
        drive(OP_SUBU, SEL_ARITH, 32'h80000000, 32'h1);
        chk("subu_wreg", 32'(wreg_o), 32'h1);
        drive(OP_SUB, SEL_ARITH, 32'h5, 32'h7);
        chk("sub_dat",  wdata_o, 32'hFFFFFFFE);
        chk("sub_wreg", 32'(wreg_o), 32'h1);

        drive(OP_OR,  SEL_LOGIC, 32'hF0F00000, 32'h00FF00FF);
        chk("or",  wdata_o, 32'hF0FF00FF);
        drive(OP_AND, SEL_LOGIC, 32'hF0F00000, 32'h00FF00FF);
        chk("and", wdata_o, 32'h00F00000);
        drive(OP_XOR, SEL_LOGIC, 32'hF0F00000, 32'h00FF00FF);
        chk("xor", wdata_o, 32'hF00F00FF);
        drive(OP_NOR, SEL_LOGIC, 32'hF0F00000, 32'h00FF00FF);
        chk("nor", wdata_o, 32'h0F00FF00);

        drive(OP_SRA, SEL_SHIFT, 32'h4, 32'h80000000);
        chk("sra4", wdata_o, 32'hF8000000);
        drive(OP_SRL, SEL_SHIFT, 32'h4, 32'h80000000);
        chk("srl4", wdata_o, 32'h08000000);
        drive(OP_SRA, SEL_SHIFT, 32'h24, 32'h80000000);
        chk("sra_shamt_wrap", wdata_o, 32'hF8000000);
        drive(OP_SLL, SEL_SHIFT, 32'd31, 32'h1);
        chk("sll31", wdata_o, 32'h80000000);

        drive(OP_SLT,  SEL_ARITH, 32'hFFFFFFFF, 32'h1);
        chk("slt",  wdata_o, 32'h1);
        drive(OP_SLTU, SEL_ARITH, 32'hFFFFFFFF, 32'h1);
        chk("sltu", wdata_o, 32'h0);
        drive(OP_OR, 3'b111, 32'hFFFFFFFF, 32'h1);
        chk("bad_sel_dat", wdata_o, 32'h0);
        chk("bad_sel_wd",  32'(wd_o), 32'd5);

        drive(OP_MULT, SEL_NOP, 32'hFFFFFFFF, 32'h2);
        tick();
        chk("mult_hi", hi_o, 32'hFFFFFFFF);
        chk("mult_lo", lo_o, 32'hFFFFFFFE);
        drive(OP_MULTU, SEL_NOP, 32'hFFFFFFFF, 32'h2);
        tick();
        chk("multu_hi", hi_o, 32'h1);
        chk("multu_lo", lo_o, 32'hFFFFFFFE);
        drive(OP_MUL, SEL_MUL, 32'hFFFFFFFD, 32'h5);
        chk("mul_dat", wdata_o, 32'hFFFFFFF1);
        tick();
        chk("mul_hi_keep", hi_o, 32'h1);
        chk("mul_lo_keep", lo_o, 32'hFFFFFFFE);

        drive(OP_MTHI, SEL_NOP, 32'h12345678, 32'h0);
        tick();
        drive(OP_MTLO, SEL_NOP, 32'h9ABCDEF0, 32'h0);
        tick();
        drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
        chk("mfhi", wdata_o, 32'h12345678);
        drive(OP_MFLO, SEL_MOVE, 32'h0, 32'h0);
        chk("mflo", wdata_o, 32'h9ABCDEF0);

        run_div("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'h2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_div("divu_100_7", OP_DIVU, 32'd100,      32'd7,        33, 32'h2,        32'hE);
        run_div("div_7_m2",   OP_DIV,  32'h7,        32'hFFFFFFFE, 33, 32'h1,        32'hFFFFFFFD);
        run_div("div_min_m1", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        32'h80000000);
        run_div("divu_5_0",   OP_DIVU, 32'h5,        32'h0,        1,  32'h5,        32'hFFFFFFFF);

        // Flush on BUSY cycle 10: HI/LO keep 5/FFFFFFFF, FSM back in IDLE.
        drive(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
        chk("fl_accept_stall", 32'(stallreq_o), 32'h1);
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        chk("fl_stall_drop", 32'(stallreq_o), 32'h0);
        tick();
        flush_i = 1'b0;
        drive(OP_OR, SEL_LOGIC, 32'h0, 32'h0);
        chk("fl_after_stall", 32'(stallreq_o), 32'h0);
        repeat (40) tick();
        chk("fl_hi_keep", hi_o, 32'h5);
        chk("fl_lo_keep", lo_o, 32'hFFFFFFFF);
        run_div("fl_idle_divu_9_0", OP_DIVU, 32'h9, 32'h0, 1, 32'h9, 32'hFFFFFFFF);

        // Reset on BUSY cycle 5 discards the divide and clears HI/LO.
        drive(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mr_stall",  32'(stallreq_o), 32'h0);
        chk("mr_wreg",   32'(wreg_o), 32'h0);
        chk("mr_wd",     32'(wd_o), 32'h0);
        chk("mr_wdata",  wdata_o, 32'h0);
        tick();
        chk("mr_hi", hi_o, 32'h0);
        chk("mr_lo", lo_o, 32'h0);
        rst = 1'b1;
        drive(OP_OR, SEL_LOGIC, 32'h0, 32'h0);
        chk("mr_after_stall", 32'(stallreq_o), 32'h0);
        run_div("mr_idle_divu_9_0", OP_DIVU, 32'h9, 32'h0, 1, 32'h9, 32'hFFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 16, 32, 64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have parameter ADDR_W, default 5, destination register address width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous and active-low.
REQ-006 SHALL have port aluOp_i  in  8  operation code, using shared op constants.
REQ-007 SHALL have port aluSel_i  in  3  result class: logic, shift, arithmetic, move, mul.
REQ-008 SHALL have ports reg1_i and reg2_i  in  WIDTH  operands.
REQ-009 SHALL have port wd_i  in  ADDR_W  and port wreg_i  in  1  destination address and write enable.
REQ-010 SHALL have port flush_i  in  1  pipeline flush; aborts any divide in progress.
REQ-011 SHALL have ports wd_o  out  ADDR_W, wreg_o  out  1, wdata_o  out  WIDTH  GPR writeback.
REQ-012 SHALL have ports hi_o and lo_o  out  WIDTH  registered HI/LO contents.
REQ-013 SHALL have port stallreq_o  out  1  stall request to pipeline control.

Function
REQ-014 Logic ops SHALL be OR, AND, NOR, XOR; shifts SLL, SRL, SRA by reg1_i[SHAMT_W-1:0]; SRA sign-fills.
REQ-015 ADD/ADDI/SUB SHALL be computed modulo 2^WIDTH; signed overflow SHALL force wreg_o=0; ADDU/SUBU never suppress.
REQ-016 SLT SHALL return 1 iff reg1_i<reg2_i signed; SLTU iff unsigned; result zero-extended to WIDTH.
REQ-017 MULT/MULTU SHALL form the full 2*WIDTH product combinationally; HI<=upper half, LO<=lower half at the next edge; no stall.
REQ-018 MUL SHALL write the lower WIDTH bits of the signed product to wdata_o; HI/LO unchanged.
REQ-019 MFHI/MFLO SHALL output current HI/LO on wdata_o; MTHI/MTLO SHALL load reg1_i into HI/LO at the next edge.
REQ-020 DIV/DIVU SHALL use an iterative restoring divider, one quotient bit per cycle, FSM states IDLE, BUSY, DONE.
REQ-021 IDLE->BUSY when a divide op is presented with reg2_i!=0 and flush_i=0; operands captured (signed: magnitudes plus result signs).
REQ-022 BUSY SHALL last exactly WIDTH cycles, counted by a $clog2(WIDTH+1)-bit counter, then go to DONE.
REQ-023 IDLE->DONE directly on divide-by-zero: quotient all ones, remainder = reg1_i.
REQ-024 In DONE, HI<=remainder and LO<=quotient at that edge (signed: remainder sign follows dividend); FSM returns to IDLE.
REQ-025 stallreq_o SHALL be 1 combinationally from the accepting cycle through BUSY; 0 in DONE and IDLE.
REQ-026 Total divide latency SHALL be WIDTH+2 cycles from acceptance to HI/LO valid; divide-by-zero takes 2.
REQ-027 flush_i=1 in any state SHALL return the FSM to IDLE next edge, drop stallreq_o, and leave HI/LO unchanged.
REQ-028 An MTHI/MTLO/MULT coinciding with DONE SHALL lose to the divide write (divide has priority).
REQ-029 wd_o SHALL equal wd_i; wdata_o SHALL be zero for unknown aluSel_i; divide ops SHALL drive wreg_o=0.

Reset
REQ-030 With rst=0 at an edge: FSM to IDLE, counter, HI, LO and divider registers to zero.
REQ-031 While rst=0, wd_o, wreg_o, wdata_o and stallreq_o SHALL be driven to zero; reset mid-divide discards it.

Structure
REQ-032 Op codes, sel codes, RstEnable/WriteEnable/ZeroWord constants SHALL live in the shared defines package.
REQ-033 The divider FSM SHALL be a sub-module div_unit with start/signed/annul inputs and ready/result outputs.

Verification
REQ-034 ADD 0x7FFFFFFF+1, wreg_i=1 -> wdata_o=0x80000000, wreg_o=0; ADDU same -> wreg_o=1.
REQ-035 SRA reg2=0x80000000, shamt=4 -> 0xF8000000; SLT -1 vs 1 -> 1; SLTU -> 0.
REQ-036 MULT 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE next edge; MULTU -> HI=1, LO=0xFFFFFFFE.
REQ-037 DIV -7/2 -> stallreq_o high 33 cycles, at cycle 34 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIVU 5/0 -> LO=0xFFFFFFFF, HI=5 after 2 cycles; flush_i at BUSY cycle 10 -> IDLE, HI/LO unchanged.
REQ-039 rst=0 at BUSY cycle 5 -> next cycle HI=LO=0, stallreq_o=0, FSM IDLE.
